counter_cycle_stealer: RTL and testbench
========================================

Name: counter_cycle_stealer

Overview:
- Shares the Core's single RAM port between the pipeline and involuntary counter increment/decrement requests (PINC/MINC style cycle stealing).
- Latches per-counter requests and services them by priority with a read-modify-write on the counter's RAM word, using 15-bit ones'-complement arithmetic.
- Asserts stall to freeze the pipeline while it owns the RAM port.
- Sits between the Core's RAM outputs and the RAM macro.

Parameters:
- NUM_CTR, 8: number of counters; counter i lives at RAM address CTR_BASE+i.
- CTR_BASE, 15'o00024: RAM address of counter 0.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- inc_req  input  NUM_CTR  one-cycle pulse, request +1 on counter i.
- dec_req  input  NUM_CTR  one-cycle pulse, request -1 on counter i.
- steal_inhibit  input  1  when high, no new steal starts; one already in progress completes.
- core_read_address  input  15  Core RAM read address.
- core_write_address  input  15  Core RAM write address.
- core_write_data  input  15  Core RAM write data.
- core_write_en  input  1  Core RAM write enable.
- RAM_read_data  input  15  RAM read data; valid the cycle after the address.
- RAM_read_address  output  15  to RAM.
- RAM_write_address  output  15  to RAM.
- RAM_write_data  output  15  to RAM.
- RAM_write_en  output  1  to RAM.
- stall  output  1  freeze pipeline.
- overflow  output  NUM_CTR  one-cycle pulse on counter i overflow or underflow.
- busy  output  1  high whenever a request is pending or a steal is in progress.

Behaviour:
- **Pending state:** pend_inc[i] and pend_dec[i] are sticky bits.
  - A request pulse sets its bit.
  - If both bits of a counter are set in the same cycle, or one is set while the other is pending, both clear (net zero).
  - A repeated request of the same kind while that bit is already pending is merged: it is lost by design.
- **FSM states:** IDLE, READ, WRITE.
- **IDLE:**
  - stall=0; RAM ports pass the core_* signals through.
  - If any pending bit is set and steal_inhibit=0:
    - Select the lowest index i with a pending bit.
    - Capture i and its direction.
    - Clear that pending bit in the same cycle.
    - Go to READ.
- **READ:**
  - stall=1.
  - RAM_read_address = CTR_BASE+i; RAM_write_en=0.
  - Go to WRITE.
- **WRITE:**
  - stall=1.
  - Compute the result combinationally from RAM_read_data.
  - RAM_write_address = CTR_BASE+i; RAM_write_en=1.
  - Pulse overflow[i] this cycle if a wrap occurred.
  - Go to IDLE.
  - An IDLE cycle always separates steals, so the core gets at least 1 of every 3 cycles.
- **Requests during a steal:**
  - Requests arriving in READ/WRITE, including for the in-service counter, set pending bits normally.
  - The in-service counter is eligible again after the write, reading the updated value.
- **stall timing:** asserted combinationally from state, so the pipeline sees it in the same cycle as READ.
  - core_write_en asserted during READ/WRITE is ignored. The Core must hold it while stalled.
- **Increment (15-bit ones' complement, bit 14 = sign):**
  - 0o37777 → 0o00000 with overflow.
  - 0o77777 (-0) → 0o00001.
  - Otherwise binary +1 mod 2^15.
- **Decrement:**
  - 0o40000 → 0o77777 with overflow.
  - 0o00000 (+0) → 0o77776.
  - Otherwise binary -1 mod 2^15.
- **Reset (asynchronous, reset_n low):**
  - State IDLE; all pending bits clear; overflow=0; stall=0; busy=0; RAM_write_en = core_write_en passthrough.
  - Reset mid-steal abandons the write; no partial write occurs.
- **steal_inhibit:** sampled only in IDLE.

Test Plan:
- Reset, inc_req[2] pulse, RAM[0o26]=0o00005, steal_inhibit=0.
  - Required: READ next cycle with stall=1 and RAM_read_address=0o26.
  - Following cycle: write 0o00006 to 0o26 with RAM_write_en=1; stall low again after.
- inc_req[0] on RAM[0o24]=0o37777.
  - Required: write 0o00000 and overflow[0]=1 for exactly one cycle.
- dec_req[1] on RAM[0o25]=0o00000.
  - Required: write 0o77776 with no overflow.
- dec_req[1] on RAM[0o25]=0o40000.
  - Required: write 0o77777 with overflow[1] pulse.
- Same cycle inc_req=8'b0000_0101 and dec_req=8'b0000_0100.
  - Required: counter 2 cancels; only counter 0 serviced.
  - stall high exactly 2 cycles; busy then falls.
- inc_req[3] and inc_req[5] together with steal_inhibit=1 for 4 cycles, then 0.
  - Required: no stall while inhibited.
  - Then counter 3 is serviced, one IDLE cycle passes with core passthrough, then counter 5.
  - reset_n pulsed low during the counter-5 READ: no write, pending cleared, stall=0 immediately.

Source files
------------

// File: rtl/counter_cycle_stealer.sv
// Counter cycle stealer: arbitrates the Core's single RAM port between the
// pipeline and involuntary counter +1/-1 requests. Each request is latched
// as a sticky pending bit and serviced by a two-cycle read-modify-write on
// the counter's RAM word. The write uses 15-bit ones'-complement arithmetic.
module counter_cycle_stealer #(
    parameter int unsigned NUM_CTR  = 8,
    parameter logic [14:0] CTR_BASE = 15'o00024
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_CTR-1:0] inc_req,
    input  logic [NUM_CTR-1:0] dec_req,
    input  logic               steal_inhibit,
    input  logic [14:0]        core_read_address,
    input  logic [14:0]        core_write_address,
    input  logic [14:0]        core_write_data,
    input  logic               core_write_en,
    input  logic [14:0]        RAM_read_data,
    output logic [14:0]        RAM_read_address,
    output logic [14:0]        RAM_write_address,
    output logic [14:0]        RAM_write_data,
    output logic               RAM_write_en,
    output logic               stall,
    output logic [NUM_CTR-1:0] overflow,
    output logic               busy
);

    localparam int unsigned IdxW = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e             state;
    logic [NUM_CTR-1:0] pend_inc;
    logic [NUM_CTR-1:0] pend_dec;
    logic [IdxW-1:0]    svc_idx;
    logic               svc_inc;

    logic [NUM_CTR-1:0] pend_any;
    logic               pick_valid;
    logic [IdxW-1:0]    pick_idx;
    logic               start;
    logic [NUM_CTR-1:0] claim_mask;
    logic [NUM_CTR-1:0] inc_keep;
    logic [NUM_CTR-1:0] dec_keep;
    logic [NUM_CTR-1:0] cancel;
    logic [NUM_CTR-1:0] pend_inc_d;
    logic [NUM_CTR-1:0] pend_dec_d;
    logic [14:0]        ctr_addr;
    logic [14:0]        result;
    logic               wrap;

    // Pick the lowest-index pending counter and decide whether a steal starts.
    always_comb begin
        pend_any   = pend_inc | pend_dec;
        pick_valid = |pend_any;
        pick_idx   = '0;
        for (int i = int'(NUM_CTR) - 1; i >= 0; i--) begin
            if (pend_any[i]) begin
                pick_idx = IdxW'(i);
            end
        end
        start      = (state == StIdle) && pick_valid && !steal_inhibit;
        claim_mask = start ? (NUM_CTR'(1) << pick_idx) : '0;
    end

    // Next pending state: drop the claimed bit, merge new pulses, then cancel
    // opposite-direction pairs so a +1/-1 pair never costs a steal.
    always_comb begin
        inc_keep   = (pend_inc & ~claim_mask) | inc_req;
        dec_keep   = (pend_dec & ~claim_mask) | dec_req;
        cancel     = inc_keep & dec_keep;
        pend_inc_d = inc_keep & ~cancel;
        pend_dec_d = dec_keep & ~cancel;
    end

    // Steal FSM plus pending bits; reset abandons any steal before its write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            pend_inc <= '0;
            pend_dec <= '0;
            svc_idx  <= '0;
            svc_inc  <= 1'b0;
        end else begin
            pend_inc <= pend_inc_d;
            pend_dec <= pend_dec_d;
            case (state)
                StIdle: begin
                    if (start) begin
                        svc_idx <= pick_idx;
                        svc_inc <= pend_inc[pick_idx];
                        state   <= StRead;
                    end
                end
                StRead:  state <= StWrite;
                StWrite: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Ones'-complement +1/-1: skip the negative-zero encoding and flag wraps
    // across the largest-magnitude values.
    always_comb begin
        wrap = 1'b0;
        if (svc_inc) begin
            if (RAM_read_data == 15'o37777) begin
                result = 15'o00000;
                wrap   = 1'b1;
            end else if (RAM_read_data == 15'o77777) begin
                result = 15'o00001;
            end else begin
                result = RAM_read_data + 15'd1;
            end
        end else begin
            if (RAM_read_data == 15'o40000) begin
                result = 15'o77777;
                wrap   = 1'b1;
            end else if (RAM_read_data == 15'o00000) begin
                result = 15'o77776;
            end else begin
                result = RAM_read_data - 15'd1;
            end
        end
    end

    assign ctr_addr = CTR_BASE + 15'(svc_idx);

    // RAM port mux: core passthrough in IDLE, stealer owns the port otherwise.
    always_comb begin
        RAM_read_address  = core_read_address;
        RAM_write_address = core_write_address;
        RAM_write_data    = core_write_data;
        RAM_write_en      = core_write_en;
        stall             = 1'b0;
        overflow          = '0;
        case (state)
            StRead: begin
                stall            = 1'b1;
                RAM_read_address = ctr_addr;
                RAM_write_en     = 1'b0;
            end
            StWrite: begin
                stall             = 1'b1;
                RAM_write_address = ctr_addr;
                RAM_write_data    = result;
                RAM_write_en      = 1'b1;
                overflow          = wrap ? (NUM_CTR'(1) << svc_idx) : '0;
            end
            default: ;
        endcase
    end

    // Busy covers both queued work and a steal in flight.
    always_comb begin
        busy = pick_valid || (state != StIdle);
    end

endmodule

// File: tb/tb_counter_cycle_stealer.sv
// Directed bench for counter_cycle_stealer with a synchronous-read RAM model.
module tb_counter_cycle_stealer;

    logic        clock;
    logic        reset_n;
    logic [7:0]  inc_req;
    logic [7:0]  dec_req;
    logic        steal_inhibit;
    logic [14:0] core_read_address;
    logic [14:0] core_write_address;
    logic [14:0] core_write_data;
    logic        core_write_en;
    logic [14:0] RAM_read_data;
    logic [14:0] RAM_read_address;
    logic [14:0] RAM_write_address;
    logic [14:0] RAM_write_data;
    logic        RAM_write_en;
    logic        stall;
    logic [7:0]  overflow;
    logic        busy;

    int n_checks;
    int n_fail;

    logic [14:0] mem [0:32767];
    logic [14:0] rd_q;

    counter_cycle_stealer #(
        .NUM_CTR  (8),
        .CTR_BASE (15'o00024)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .inc_req            (inc_req),
        .dec_req            (dec_req),
        .steal_inhibit      (steal_inhibit),
        .core_read_address  (core_read_address),
        .core_write_address (core_write_address),
        .core_write_data    (core_write_data),
        .core_write_en      (core_write_en),
        .RAM_read_data      (RAM_read_data),
        .RAM_read_address   (RAM_read_address),
        .RAM_write_address  (RAM_write_address),
        .RAM_write_data     (RAM_write_data),
        .RAM_write_en       (RAM_write_en),
        .stall              (stall),
        .overflow           (overflow),
        .busy               (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: read data valid the cycle after the address.
    always @(posedge clock) begin
        if (RAM_write_en) mem[RAM_write_address] <= RAM_write_data;
        rd_q <= mem[RAM_read_address];
    end
    assign RAM_read_data = rd_q;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Load a RAM word through the core write passthrough (must be idle).
    task automatic preload(input logic [14:0] a, input logic [14:0] d);
        core_write_address = a;
        core_write_data    = d;
        core_write_en      = 1'b1;
        step();
        core_write_en      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        core_write_address = 15'o00100;
        core_write_en = 1'b1;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (overflow !== 8'h00) begin n_fail++; $display("FAIL reset_ovf got %h exp 00", overflow); end
        n_checks++; if (RAM_write_en !== 1'b1) begin n_fail++; $display("FAIL reset_we_pass got %b exp 1", RAM_write_en); end
        n_checks++; if (RAM_read_address !== 15'o01234) begin n_fail++; $display("FAIL reset_ra_pass got %o exp 1234", RAM_read_address); end
        step();
        core_write_en = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_steal();
        preload(15'o00026, 15'o00005);
        inc_req = 8'b0000_0100;
        step();
        inc_req = 8'b0;
        @(negedge clock);
        n_checks++; if (stall !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_pend stall/busy got %b%b exp 01", stall, busy); end
        step();
        // Core write attempted while stalled must not reach the RAM.
        core_write_address = 15'o00200;
        core_write_data    = 15'o07070;
        core_write_en      = 1'b1;
        @(negedge clock);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL basic_read_stall got %b exp 1", stall); end
        n_checks++; if (RAM_read_address !== 15'o00026) begin n_fail++; $display("FAIL basic_read_addr got %o exp 26", RAM_read_address); end
        n_checks++; if (RAM_write_en !== 1'b0) begin n_fail++; $display("FAIL basic_read_we got %b exp 0", RAM_write_en); end
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b1 || RAM_write_en !== 1'b1) begin n_fail++; $display("FAIL basic_write_ctl stall/we got %b%b exp 11", stall, RAM_write_en); end
        n_checks++; if (RAM_write_address !== 15'o00026) begin n_fail++; $display("FAIL basic_write_addr got %o exp 26", RAM_write_address); end
        n_checks++; if (RAM_write_data !== 15'o00006) begin n_fail++; $display("FAIL basic_write_data got %o exp 6", RAM_write_data); end
        core_write_en = 1'b0;
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_after stall/busy got %b%b exp 00", stall, busy); end
        n_checks++; if (RAM_read_address !== 15'o01234) begin n_fail++; $display("FAIL basic_pass_ra got %o exp 1234", RAM_read_address); end
        n_checks++; if (mem[15'o00026] !== 15'o00006) begin n_fail++; $display("FAIL basic_mem got %o exp 6", mem[15'o00026]); end
        n_checks++; if (mem[15'o00200] === 15'o07070) begin n_fail++; $display("FAIL basic_core_we_ignored got %o exp not 7070", mem[15'o00200]); end
        step();
    endtask

    task automatic test_arith();
        int          idx_v [8];
        logic        inc_v [8];
        logic [14:0] init_v [8];
        logic [14:0] exp_v [8];
        logic        ovf_v [8];
        logic [14:0] a;
        logic [7:0]  m;
        logic [7:0]  exp_ovf;
        idx_v  = '{0, 1, 1, 7, 6, 4, 3, 5};
        inc_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        init_v = '{15'o37777, 15'o00000, 15'o40000, 15'o77777,
                   15'o77777, 15'o77776, 15'o00001, 15'o12345};
        exp_v  = '{15'o00000, 15'o77776, 15'o77777, 15'o00001,
                   15'o77776, 15'o77777, 15'o00000, 15'o12346};
        ovf_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            a       = 15'o00024 + 15'(idx_v[k]);
            m       = 8'b1 << idx_v[k];
            exp_ovf = ovf_v[k] ? m : 8'h00;
            preload(a, init_v[k]);
            if (inc_v[k]) inc_req = m; else dec_req = m;
            step();
            inc_req = 8'b0;
            dec_req = 8'b0;
            step();
            @(negedge clock);
            n_checks++; if (stall !== 1'b1 || RAM_read_address !== a) begin n_fail++; $display("FAIL arith%0d_read stall=%b addr=%o exp 1/%o", k, stall, RAM_read_address, a); end
            step();
            @(negedge clock);
            n_checks++; if (RAM_write_data !== exp_v[k]) begin n_fail++; $display("FAIL arith%0d_data got %o exp %o", k, RAM_write_data, exp_v[k]); end
            n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL arith%0d_ovf got %b exp %b", k, overflow, exp_ovf); end
            step();
            @(negedge clock);
            n_checks++; if (overflow !== 8'h00 || stall !== 1'b0) begin n_fail++; $display("FAIL arith%0d_after ovf=%b stall=%b exp 0/0", k, overflow, stall); end
            n_checks++; if (mem[a] !== exp_v[k]) begin n_fail++; $display("FAIL arith%0d_mem got %o exp %o", k, mem[a], exp_v[k]); end
            step();
        end
    endtask

    task automatic test_cancel();
        int          stall_cycles;
        logic [14:0] seen_addr;
        stall_cycles = 0;
        seen_addr    = 15'o0;
        preload(15'o00024, 15'o00010);
        preload(15'o00026, 15'o00020);
        inc_req = 8'b0000_0101;
        dec_req = 8'b0000_0100;
        step();
        inc_req = 8'b0;
        dec_req = 8'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (stall === 1'b1) begin
                stall_cycles++;
                if (RAM_write_en === 1'b0) seen_addr = RAM_read_address;
            end
            step();
        end
        n_checks++; if (stall_cycles != 2) begin n_fail++; $display("FAIL cancel_stall_cycles got %0d exp 2", stall_cycles); end
        n_checks++; if (seen_addr !== 15'o00024) begin n_fail++; $display("FAIL cancel_read_addr got %o exp 24", seen_addr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b exp 0", busy); end
        n_checks++; if (mem[15'o00024] !== 15'o00011) begin n_fail++; $display("FAIL cancel_mem0 got %o exp 11", mem[15'o00024]); end
        n_checks++; if (mem[15'o00026] !== 15'o00020) begin n_fail++; $display("FAIL cancel_mem2 got %o exp 20", mem[15'o00026]); end
        // A request meeting an already-pending opposite request also cancels.
        steal_inhibit = 1'b1;
        dec_req = 8'b0100_0000;
        step();
        dec_req = 8'b0;
        inc_req = 8'b0100_0000;
        step();
        inc_req = 8'b0;
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_pending_busy got %b exp 0", busy); end
        steal_inhibit = 1'b0;
        step();
    endtask

    task automatic test_merge();
        preload(15'o00030, 15'o00007);
        steal_inhibit = 1'b1;
        inc_req = 8'b0001_0000;
        step();
        step();
        inc_req = 8'b0;
        steal_inhibit = 1'b0;
        for (int c = 0; c < 5; c++) step();
        @(negedge clock);
        n_checks++; if (mem[15'o00030] !== 15'o00010) begin n_fail++; $display("FAIL merge_mem got %o exp 10", mem[15'o00030]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL merge_busy got %b exp 0", busy); end
        step();
    endtask

    task automatic test_back_to_back();
        preload(15'o00025, 15'o00100);
        inc_req = 8'b0000_0010;
        step();
        inc_req = 8'b0;
        step();
        inc_req = 8'b0000_0010;
        @(negedge clock);
        n_checks++; if (stall !== 1'b1 || RAM_read_address !== 15'o00025) begin n_fail++; $display("FAIL b2b_read1 stall=%b addr=%o exp 1/25", stall, RAM_read_address); end
        step();
        inc_req = 8'b0;
        @(negedge clock);
        n_checks++; if (RAM_write_data !== 15'o00101) begin n_fail++; $display("FAIL b2b_write1 got %o exp 101", RAM_write_data); end
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap stall/busy got %b%b exp 01", stall, busy); end
        step();
        step();
        @(negedge clock);
        n_checks++; if (RAM_write_en !== 1'b1 || RAM_write_data !== 15'o00102) begin n_fail++; $display("FAIL b2b_write2 we=%b data=%o exp 1/102", RAM_write_en, RAM_write_data); end
        step();
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || mem[15'o00025] !== 15'o00102) begin n_fail++; $display("FAIL b2b_end busy=%b mem=%o exp 0/102", busy, mem[15'o00025]); end
        step();
    endtask

    task automatic test_inhibit_reset();
        preload(15'o00027, 15'o00200);
        preload(15'o00031, 15'o00300);
        steal_inhibit = 1'b1;
        inc_req = 8'b0010_1000;
        @(negedge clock);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL inh_stall0 got %b exp 0", stall); end
        step();
        inc_req = 8'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clock);
            n_checks++; if (stall !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL inh_stall%0d stall/busy got %b%b exp 01", c, stall, busy); end
            step();
        end
        steal_inhibit = 1'b0;
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b1 || RAM_read_address !== 15'o00027) begin n_fail++; $display("FAIL inh_read3 stall=%b addr=%o exp 1/27", stall, RAM_read_address); end
        step();
        @(negedge clock);
        n_checks++; if (RAM_write_address !== 15'o00027 || RAM_write_data !== 15'o00201) begin n_fail++; $display("FAIL inh_write3 addr=%o data=%o exp 27/201", RAM_write_address, RAM_write_data); end
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b0 || RAM_read_address !== 15'o01234 || busy !== 1'b1) begin n_fail++; $display("FAIL inh_gap stall=%b ra=%o busy=%b exp 0/1234/1", stall, RAM_read_address, busy); end
        step();
        @(negedge clock);
        n_checks++; if (stall !== 1'b1 || RAM_read_address !== 15'o00031) begin n_fail++; $display("FAIL inh_read5 stall=%b addr=%o exp 1/31", stall, RAM_read_address); end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0 || busy !== 1'b0 || RAM_write_en !== 1'b0) begin n_fail++; $display("FAIL inh_reset stall=%b busy=%b we=%b exp 0/0/0", stall, busy, RAM_write_en); end
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        @(negedge clock);
        n_checks++; if (busy !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL inh_post_busy busy/stall got %b%b exp 00", busy, stall); end
        n_checks++; if (mem[15'o00031] !== 15'o00300) begin n_fail++; $display("FAIL inh_no_write got %o exp 300", mem[15'o00031]); end
        n_checks++; if (mem[15'o00027] !== 15'o00201) begin n_fail++; $display("FAIL inh_mem3 got %o exp 201", mem[15'o00027]); end
        step();
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        reset_n            = 1'b0;
        inc_req            = 8'b0;
        dec_req            = 8'b0;
        steal_inhibit      = 1'b0;
        core_read_address  = 15'o01234;
        core_write_address = 15'o00100;
        core_write_data    = 15'o0;
        core_write_en      = 1'b0;
        test_reset();
        test_basic_steal();
        test_arith();
        test_cancel();
        test_merge();
        test_back_to_back();
        test_inhibit_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
